oled_frame_streamer: RTL
========================

// Module: oled_frame_streamer
// PURPOSE
//  SPI display-side driver for the 96x64 RGB565 PmodOLED. Runs reset/power-up and init
//  command sequences, then streams frames forever.
//  Drives pixel_index (row-major, idx = y*96 + x) to the pixel renderer and serialises
//  the renderer's combinational oled_data back over SPI.
//  Sits between the task renderers and the Pmod pins, on the 6.25 MHz clock.
// PARAMETERS
//  CLK_DIV       1      SPI half-bit period in clk cycles; bit period = 2*CLK_DIV cycles
//  RESET_CYCLES  16     clk cycles resn held low after reset release
//  POWER_CYCLES  64     clk cycles waited after vccen rises, before init commands
//  GAP_CYCLES    8      clk cycles cs held high between frames
// PORTS
//  clk            in   1   6.25 MHz system clock; all logic on posedge
//  reset          in   1   asynchronous, active-high
//  oled_data      in   16  RGB565 pixel for current pixel_index, combinational from renderer
//  pixel_index    out  13  pixel being fetched, 0..6143
//  sample_pixel   out  1   1-cycle pulse: oled_data latched this cycle
//  frame_begin    out  1   1-cycle pulse coincident with sample_pixel for index 0
//  sending_pixels out  1   high in FRAME state
//  cs             out  1   SPI chip select, active low
//  sclk           out  1   SPI clock, idle high
//  sdin           out  1   SPI data, MSB first
//  d_cn           out  1   0 = command byte, 1 = pixel data
//  resn           out  1   display reset, active low
//  vccen          out  1   panel VCC enable
//  pmoden         out  1   Pmod power enable
// BEHAVIOUR
//  Reset (async): state=RST_LOW, cs=1, sclk=1, sdin=0, d_cn=0, resn=0, vccen=0, pmoden=0,
//   pixel_index=0, sample_pixel=0, frame_begin=0, sending_pixels=0, counters=0.
//  Reset mid-operation aborts any byte or pixel at once; sequence restarts from RST_LOW.
//  FSM: RST_LOW -> PWR_WAIT -> INIT -> FRAME -> GAP -> FRAME ...
//  RST_LOW
//   - pmoden=1, resn=0 for RESET_CYCLES cycles.
//   - Then resn=1 and vccen=1; go to PWR_WAIT.
//  PWR_WAIT: count POWER_CYCLES cycles, then go to INIT.
//  INIT
//   - cs=0, d_cn=0; send 4 bytes in order: 8'hAE, 8'hA0, 8'h72, 8'hAF.
//   - cs stays low across all 4 bytes; cs=1 for one cycle after the last bit; go to FRAME.
//  Bit timing, all serial states
//   - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - sdin changes only on the cycle sclk falls.
//   - Display samples on the sclk rising edge.
//  FRAME: cs=0, d_cn=1, sending_pixels=1; 6144 pixels x 16 bits, MSB first, no gaps.
//  Pixel fetch
//   - On FRAME entry and after the last bit of each pixel: shift reg <= oled_data,
//     sample_pixel=1 for that cycle.
//   - pixel_index increments on the next cycle, giving the renderer a full pixel time.
//   - frame_begin=1 when the latched index is 0.
//   - After latching 6143, pixel_index wraps to 0.
//   - After the last bit of pixel 6143: go to GAP.
//  GAP: cs=1, sclk=1, sending_pixels=0 for GAP_CYCLES cycles, then back to FRAME.
//  Frame period = 6144*16*2*CLK_DIV + GAP_CYCLES cycles.
//   - Default: 196 608 + 8 cycles, about 31.5 ms.
//  Other rules
//   - oled_data is ignored except on sample_pixel cycles; mid-pixel changes never corrupt
//     the bits on the wire.
//   - pixel_index never exceeds 6143.
//   - counters are sized for their maximum; no arithmetic overflow.
// TESTING
//  1 Reset release
//    - resn=0 for 16 cycles, then resn=1 and vccen=1.
//    - First cs fall exactly 64 cycles later.
//  2 SPI monitor on sclk rising edges during INIT
//    - Captures AE, A0, 72, AF with d_cn=0.
//  3 Frame data
//    - Renderer returns 16'hF800 for idx 0 and 16'h07E0 for idx 1.
//    - Captured bits are F800 then 07E0, with d_cn=1; frame_begin pulses once.
//  4 Wrap
//    - Watch idx 6143 -> 0.
//    - 8 cs-high cycles, then frame_begin pulses again.
//    - Frame period is 196 616 cycles.
//  5 Reset mid-frame at pixel 100
//    - cs=1, resn=0, and pixel_index=0 immediately.
//    - Full INIT sequence is repeated.
//  6 CLK_DIV=3
//    - Every sclk phase lasts 3 cycles; sdin is stable while sclk is high.
//    - oled_data toggled mid-pixel does not change the captured word.

Source files
------------

// File: rtl/oled_frame_streamer.sv
`timescale 1ns/1ps
// SPI driver for the 96x64 RGB565 PmodOLED: power-up, init commands, then endless
// pixel frames fetched from a combinational renderer addressed by pixel_index.
module oled_frame_streamer #(
  parameter int CLK_DIV      = 1,
  parameter int RESET_CYCLES = 16,
  parameter int POWER_CYCLES = 64,
  parameter int GAP_CYCLES   = 8,
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] oled_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);
  localparam int NUM_PIXELS = WIDTH * HEIGHT;
  localparam int CNT_MAX = (RESET_CYCLES > POWER_CYCLES)
                         ? ((RESET_CYCLES > GAP_CYCLES) ? RESET_CYCLES : GAP_CYCLES)
                         : ((POWER_CYCLES > GAP_CYCLES) ? POWER_CYCLES : GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWER_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_PRE  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [12:0]      IDX_LAST = 13'(NUM_PIXELS - 1);
  localparam logic [7:0]       FIRST_CMD = 8'hAE;

  typedef enum logic [2:0] {RST_LOW, PWR_WAIT, INIT, FRAME, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [15:0]      shreg;

  logic [7:0]  next_cmd;
  logic        tick;
  logic        pre_last;
  logic [12:0] idx_inc;

  function automatic logic [7:0] init_byte(input logic [1:0] n);
    case (n)
      2'd0:    return 8'hAE;
      2'd1:    return 8'hA0;
      2'd2:    return 8'h72;
      default: return 8'hAF;
    endcase
  endfunction

  // pre_last marks the edge that enters the final cycle of the current bit, so the
  // next pixel can be sampled in that cycle and loaded with no gap on the wire.
  always_comb begin
    next_cmd = init_byte(byte_cnt + 2'd1);
    tick     = (div_cnt == DIV_LAST);
    if (CLK_DIV == 1) pre_last = !sclk && tick;
    else              pre_last = sclk && (div_cnt == DIV_PRE);
    idx_inc  = (pixel_index == IDX_LAST) ? 13'd0 : pixel_index + 13'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RST_LOW;
      cnt            <= '0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      shreg          <= '0;
      pixel_index    <= '0;
      sample_pixel   <= 1'b0;
      frame_begin    <= 1'b0;
      sending_pixels <= 1'b0;
      cs             <= 1'b1;
      sclk           <= 1'b1;
      sdin           <= 1'b0;
      d_cn           <= 1'b0;
      resn           <= 1'b0;
      vccen          <= 1'b0;
      pmoden         <= 1'b0;
    end else begin
      sample_pixel <= 1'b0;
      frame_begin  <= 1'b0;
      case (state)
        RST_LOW: begin
          pmoden <= 1'b1;
          if (cnt == RST_LAST) begin
            resn  <= 1'b1;
            vccen <= 1'b1;
            cnt   <= '0;
            state <= PWR_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PWR_WAIT: begin
          if (cnt == PWR_LAST) begin
            state    <= INIT;
            cnt      <= '0;
            cs       <= 1'b0;
            d_cn     <= 1'b0;
            sclk     <= 1'b0;
            shreg    <= {FIRST_CMD, 8'h00};
            sdin     <= FIRST_CMD[7];
            byte_cnt <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        INIT: begin
          if (!tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt != 4'd7) begin
              bit_cnt <= bit_cnt + 4'd1;
              sclk    <= 1'b0;
              shreg   <= {shreg[14:0], 1'b0};
              sdin    <= shreg[14];
            end else if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              bit_cnt  <= '0;
              sclk     <= 1'b0;
              shreg    <= {next_cmd, 8'h00};
              sdin     <= next_cmd[7];
            end else begin
              // One cs-high cycle doubles as the sample cycle for pixel 0.
              cs             <= 1'b1;
              d_cn           <= 1'b1;
              state          <= FRAME;
              sending_pixels <= 1'b1;
              sample_pixel   <= 1'b1;
              frame_begin    <= (pixel_index == 13'd0);
            end
          end
        end
        FRAME, GAP: begin
          if (sample_pixel) begin
            state          <= FRAME;
            cs             <= 1'b0;
            sclk           <= 1'b0;
            sending_pixels <= 1'b1;
            shreg          <= oled_data;
            sdin           <= oled_data[15];
            bit_cnt        <= '0;
            div_cnt        <= '0;
            pixel_index    <= idx_inc;
          end else if (state == GAP) begin
            cnt <= cnt + CNT_W'(1);
            if (GAP_CYCLES > 1 && cnt == GAP_PRE) begin
              sample_pixel <= 1'b1;
              frame_begin  <= (pixel_index == 13'd0);
            end
          end else begin
            // pixel_index already wrapped to 0 while the frame's last pixel is on the wire.
            if (pre_last && bit_cnt == 4'd15 && pixel_index != 13'd0)
              sample_pixel <= 1'b1;
            if (!tick) begin
              div_cnt <= div_cnt + DIV_W'(1);
            end else begin
              div_cnt <= '0;
              if (!sclk) begin
                sclk <= 1'b1;
              end else if (bit_cnt != 4'd15) begin
                bit_cnt <= bit_cnt + 4'd1;
                sclk    <= 1'b0;
                shreg   <= {shreg[14:0], 1'b0};
                sdin    <= shreg[14];
              end else begin
                state          <= GAP;
                cs             <= 1'b1;
                sclk           <= 1'b1;
                sending_pixels <= 1'b0;
                cnt            <= '0;
                if (GAP_CYCLES == 1) begin
                  sample_pixel <= 1'b1;
                  frame_begin  <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= RST_LOW;
      endcase
    end
  end
endmodule
